tdm_burst_framer: RTL and testbench

- Downstream of post_processing, in the clk100m domain. Consumes the 17-bit result stream (8+8+1) and buffers it in a small FIFO.
- Emits fixed-length frames: sync header, BURST_LEN payload words, optional checksum trailer. Output uses a valid/ready handshake toward the board-level output interface.
- Sticky overflow flag and a completed-frame counter for debug.

---
 rtl/tdm_pkg.sv | 21 ++
 rtl/sync_fifo.sv | 67 ++++++
 rtl/tdm_burst_framer.sv | 190 +++++++++++++++++++
 tb/tb_tdm_burst_framer.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdm_pkg.sv
// ---------------------------------------------------------------------------
// tdm_pkg
// Shared types and constants for the TDM burst framer (clk100m domain).
//   DATA_W            : width of the post_processing result word (8+8+1)
//   SYNC_WORD_DEFAULT : default frame header word
//   framer_state_t    : framer FSM states
// ---------------------------------------------------------------------------
package tdm_pkg;

  localparam int DATA_W = 17;

  localparam logic [DATA_W-1:0] SYNC_WORD_DEFAULT = 17'h1_5A5A;

  typedef enum logic [1:0] {
    IDLE,
    HDR,
    PAYLOAD,
    TRAILER
  } framer_state_t;

endpackage

// File: rtl/sync_fifo.sv
// ---------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with an occupancy counter.
//   clk, rst : clock, synchronous active-high reset (empties the FIFO)
//   wr_en    : write request, ignored while full
//   wr_data  : write word
//   rd_en    : pop request, ignored while empty
//   rd_data  : head word, driven from the storage registers
//   full     : count == DEPTH
//   empty    : count == 0
//   count    : registered occupancy, 0..DEPTH
// DEPTH must be a power of two so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 16,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             pop;

  // Flags derive from the registered count only, so a write is refused while
  // full even when a pop happens in the same cycle.
  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage is data only; it carries no reset.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/tdm_burst_framer.sv
// ---------------------------------------------------------------------------
// tdm_burst_framer
// Buffers the post_processing result stream and emits fixed-length frames:
// sync header, BURST_LEN payload words and, when TDM_FRAMER_CHECKSUM_EN is
// defined, an XOR checksum trailer. Output uses a valid/ready handshake.
//   clk, rst   : clk100m, synchronous active-high reset
//   din        : input word, din_valid qualifies it
//   dout       : framed output word, dout_valid qualifies it
//   dout_ready : consumer accepts dout on dout_valid && dout_ready
//   dout_sof   : high with the header word
//   dout_eof   : high with the last word of the frame
//   overflow   : sticky, an input word was dropped because the FIFO was full
//   frame_cnt  : completed frames, wraps at 16 bits
// Optional macro: TDM_FRAMER_CHECKSUM_EN (adds the checksum trailer).
// ---------------------------------------------------------------------------
module tdm_burst_framer
  import tdm_pkg::*;
#(
  parameter int               WIDTH      = DATA_W,
  parameter int               BURST_LEN  = 8,
  parameter int               FIFO_DEPTH = 16,
  parameter logic [WIDTH-1:0] SYNC_WORD  = WIDTH'(SYNC_WORD_DEFAULT)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             dout_sof,
  output logic             dout_eof,
  output logic             overflow,
  output logic [15:0]      frame_cnt
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = $clog2(BURST_LEN);

  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(BURST_LEN - 1);
`ifndef TDM_FRAMER_CHECKSUM_EN
  localparam logic [IDX_W-1:0] PRE_LAST  = IDX_W'(BURST_LEN - 2);
`endif

  framer_state_t    state;
  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] fifo_head;
  logic [CNT_W-1:0] fifo_count;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic             xfer;
  logic             burst_ready;
`ifdef TDM_FRAMER_CHECKSUM_EN
  logic [WIDTH-1:0] csum;
`endif

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (din_valid),
    .wr_data (din),
    .rd_en   (fifo_pop),
    .rd_data (fifo_head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign xfer        = dout_valid && dout_ready;
  assign burst_ready = (fifo_count >= BURST_CNT);

  // The output register refills from the FIFO head in the same cycle the
  // current word is accepted: on the header, and on every payload word except
  // the last (the last one's successor is the trailer or the next header).
  assign fifo_pop = xfer && !fifo_empty &&
                    ((state == HDR) || ((state == PAYLOAD) && (idx != LAST_IDX)));

  // --- framer FSM and registered output stage ---
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      idx        <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      dout_sof   <= 1'b0;
      dout_eof   <= 1'b0;
      frame_cnt  <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          // A frame only starts with a whole burst buffered, so the payload
          // can never underrun mid-frame.
          if (burst_ready) begin
            dout       <= SYNC_WORD;
            dout_valid <= 1'b1;
            dout_sof   <= 1'b1;
            dout_eof   <= 1'b0;
            state      <= HDR;
          end
        end

        HDR: begin
          if (xfer) begin
            dout     <= fifo_head;
            dout_sof <= 1'b0;
            dout_eof <= 1'b0;
            idx      <= '0;
            state    <= PAYLOAD;
`ifdef TDM_FRAMER_CHECKSUM_EN
            csum     <= '0;
`endif
          end
        end

        PAYLOAD: begin
          if (xfer) begin
`ifdef TDM_FRAMER_CHECKSUM_EN
            csum <= csum ^ dout;
`endif
            if (idx != LAST_IDX) begin
              dout <= fifo_head;
              idx  <= idx + 1'b1;
`ifndef TDM_FRAMER_CHECKSUM_EN
              dout_eof <= (idx == PRE_LAST);
`endif
            end else begin
`ifdef TDM_FRAMER_CHECKSUM_EN
              // The word being accepted is folded in directly so the trailer
              // is ready on the very next cycle.
              dout     <= csum ^ dout;
              dout_eof <= 1'b1;
              state    <= TRAILER;
`else
              frame_cnt <= frame_cnt + 16'd1;
              dout_eof  <= 1'b0;
              if (burst_ready) begin
                dout     <= SYNC_WORD;
                dout_sof <= 1'b1;
                state    <= HDR;
              end else begin
                dout_valid <= 1'b0;
                state      <= IDLE;
              end
`endif
            end
          end
        end

`ifdef TDM_FRAMER_CHECKSUM_EN
        TRAILER: begin
          if (xfer) begin
            frame_cnt <= frame_cnt + 16'd1;
            dout_eof  <= 1'b0;
            if (burst_ready) begin
              dout     <= SYNC_WORD;
              dout_sof <= 1'b1;
              state    <= HDR;
            end else begin
              dout_valid <= 1'b0;
              state      <= IDLE;
            end
          end
        end
`endif

        default: begin
          dout_valid <= 1'b0;
          dout_sof   <= 1'b0;
          dout_eof   <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

  // --- sticky overflow ---
  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (din_valid && fifo_full) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_tdm_burst_framer.sv
// ---------------------------------------------------------------------------
// tb_tdm_burst_framer
// Directed bench for tdm_burst_framer at default parameters. Frame length
// follows TDM_FRAMER_CHECKSUM_EN.
// ---------------------------------------------------------------------------
module tb_tdm_burst_framer;

  localparam logic [16:0] SYNC = 17'h15A5A;
`ifdef TDM_FRAMER_CHECKSUM_EN
  localparam int FLEN = 10;
`else
  localparam int FLEN = 9;
`endif

  logic        clk;
  logic        rst;
  logic [16:0] din;
  logic        din_valid;
  logic [16:0] dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_sof;
  logic        dout_eof;
  logic        overflow;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [16:0] cap_d[$];
  bit          cap_sof[$];
  bit          cap_eof[$];
  int          cap_cyc[$];

  bit          stall_prev = 0;
  logic [16:0] stall_d;
  bit          stall_sof;
  bit          stall_eof;
  int          stall_viol = 0;
  int          stall_cycles = 0;

  tdm_burst_framer dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .dout_sof   (dout_sof),
    .dout_eof   (dout_eof),
    .overflow   (overflow),
    .frame_cnt  (frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst && dout_valid && dout_ready) begin
      cap_d.push_back(dout);
      cap_sof.push_back(dout_sof);
      cap_eof.push_back(dout_eof);
      cap_cyc.push_back(cyc);
    end
    if (!rst && stall_prev) begin
      if (dout_valid !== 1'b1 || dout !== stall_d || dout_sof !== stall_sof ||
          dout_eof !== stall_eof)
        stall_viol++;
    end
    stall_prev = !rst && dout_valid && !dout_ready;
    stall_d    = dout;
    stall_sof  = dout_sof;
    stall_eof  = dout_eof;
    if (stall_prev) stall_cycles++;
  end

  function automatic logic [16:0] exp_word(int first, int k);
    logic [16:0] x;
    x = '0;
    if (k == 0) return SYNC;
    if (k <= 8) return 17'(first + k - 1);
    for (int i = 0; i < 8; i++) x ^= 17'(first + i);
    return x;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_capture();
    cap_d.delete();
    cap_sof.delete();
    cap_eof.delete();
    cap_cyc.delete();
    stall_viol   = 0;
    stall_cycles = 0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    clear_capture();
  endtask

  task automatic write_words(input int first, input int n, output int last_cyc);
    last_cyc = 0;
    for (int i = 0; i < n; i++) begin
      din       = 17'(first + i);
      din_valid = 1'b1;
      last_cyc  = cyc;
      tick();
    end
    din_valid = 1'b0;
  endtask

  task automatic wait_words(input int n, input int budget);
    for (int c = 0; c < budget && cap_d.size() < n; c++) tick();
  endtask

  task automatic test_reset();
    rst        = 1'b1;
    din_valid  = 1'b1;
    din        = 17'h1FFFF;
    dout_ready = 1'b1;
    tick();
    tick();
    din_valid = 1'b0;
    rst       = 1'b0;
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", dout_valid); end
    checks++; if (dout !== 17'h0) begin errors++; $display("FAIL reset_dout: got %h expected 00000", dout); end
    checks++; if (dout_sof !== 1'b0) begin errors++; $display("FAIL reset_sof: got %b expected 0", dout_sof); end
    checks++; if (dout_eof !== 1'b0) begin errors++; $display("FAIL reset_eof: got %b expected 0", dout_eof); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b expected 0", overflow); end
    checks++; if (frame_cnt !== 16'h0) begin errors++; $display("FAIL reset_frame_cnt: got %h expected 0000", frame_cnt); end
  endtask

  task automatic test_basic();
    int last_cyc;
    int n;
    do_reset();
    dout_ready = 1'b1;
    write_words(1, 8, last_cyc);
    wait_words(FLEN, 60);
    checks++; if (cap_d.size() != FLEN) begin errors++; $display("FAIL basic_len: got %0d words expected %0d", cap_d.size(), FLEN); end
    n = (cap_d.size() < FLEN) ? cap_d.size() : FLEN;
    if (n > 0) begin
      checks++; if (cap_cyc[0] != last_cyc + 2) begin errors++; $display("FAIL basic_latency: header at cycle %0d expected %0d", cap_cyc[0], last_cyc + 2); end
    end
    for (int k = 0; k < n; k++) begin
      checks++; if (cap_d[k] !== exp_word(1, k)) begin errors++; $display("FAIL basic_word[%0d]: got %h expected %h", k, cap_d[k], exp_word(1, k)); end
      checks++; if (cap_sof[k] !== (k == 0)) begin errors++; $display("FAIL basic_sof[%0d]: got %b expected %b", k, cap_sof[k], (k == 0)); end
      checks++; if (cap_eof[k] !== (k == FLEN - 1)) begin errors++; $display("FAIL basic_eof[%0d]: got %b expected %b", k, cap_eof[k], (k == FLEN - 1)); end
    end
    tick(); tick(); tick();
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL basic_frame_cnt: got %0d expected 1", frame_cnt); end
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL basic_idle: dout_valid got %b expected 0", dout_valid); end
  endtask

  task automatic test_backpressure();
    int last_cyc;
    int n;
    bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    do_reset();
    fork
      write_words(1, 8, last_cyc);
      for (int c = 0; c < 300 && cap_d.size() < FLEN; c++) begin
        dout_ready = pat[c % 4];
        tick();
      end
    join
    dout_ready = 1'b1;
    checks++; if (cap_d.size() != FLEN) begin errors++; $display("FAIL bp_len: got %0d words expected %0d", cap_d.size(), FLEN); end
    n = (cap_d.size() < FLEN) ? cap_d.size() : FLEN;
    for (int k = 0; k < n; k++) begin
      checks++; if (cap_d[k] !== exp_word(1, k)) begin errors++; $display("FAIL bp_word[%0d]: got %h expected %h", k, cap_d[k], exp_word(1, k)); end
      checks++; if (cap_sof[k] !== (k == 0)) begin errors++; $display("FAIL bp_sof[%0d]: got %b expected %b", k, cap_sof[k], (k == 0)); end
      checks++; if (cap_eof[k] !== (k == FLEN - 1)) begin errors++; $display("FAIL bp_eof[%0d]: got %b expected %b", k, cap_eof[k], (k == FLEN - 1)); end
    end
    checks++; if (stall_cycles == 0) begin errors++; $display("FAIL bp_stalls: got %0d stall cycles expected >0", stall_cycles); end
    checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_stable: got %0d unstable stall cycles expected 0", stall_viol); end
    tick(); tick(); tick();
    checks++; if (cap_d.size() != FLEN) begin errors++; $display("FAIL bp_extra: got %0d words expected %0d", cap_d.size(), FLEN); end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL bp_frame_cnt: got %0d expected 1", frame_cnt); end
  endtask

  task automatic test_back_to_back();
    int last_cyc;
    int n;
    do_reset();
    dout_ready = 1'b1;
    write_words(17'h20, 16, last_cyc);
    wait_words(2 * FLEN, 80);
    checks++; if (cap_d.size() != 2 * FLEN) begin errors++; $display("FAIL b2b_len: got %0d words expected %0d", cap_d.size(), 2 * FLEN); end
    n = (cap_d.size() < 2 * FLEN) ? cap_d.size() : 2 * FLEN;
    for (int j = 0; j < n; j++) begin
      checks++; if (cap_d[j] !== exp_word(32'h20 + 8 * (j / FLEN), j % FLEN)) begin errors++; $display("FAIL b2b_word[%0d]: got %h expected %h", j, cap_d[j], exp_word(32'h20 + 8 * (j / FLEN), j % FLEN)); end
      checks++; if (cap_sof[j] !== (j % FLEN == 0)) begin errors++; $display("FAIL b2b_sof[%0d]: got %b expected %b", j, cap_sof[j], (j % FLEN == 0)); end
      checks++; if (cap_eof[j] !== (j % FLEN == FLEN - 1)) begin errors++; $display("FAIL b2b_eof[%0d]: got %b expected %b", j, cap_eof[j], (j % FLEN == FLEN - 1)); end
      checks++; if (cap_cyc[j] != cap_cyc[0] + j) begin errors++; $display("FAIL b2b_gap[%0d]: at cycle %0d expected %0d", j, cap_cyc[j], cap_cyc[0] + j); end
    end
    tick(); tick(); tick();
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL b2b_frame_cnt: got %0d expected 2", frame_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL b2b_overflow: got %b expected 0", overflow); end
  endtask

  task automatic test_overflow();
    int n;
    do_reset();
    dout_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      din       = 17'(32'h40 + i);
      din_valid = 1'b1;
      tick();
      if (i == 15) begin
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL ovf_before: got %b expected 0 after 16 writes", overflow); end
      end
      if (i == 16) begin
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1 after 17th write", overflow); end
      end
    end
    din_valid = 1'b0;
    checks++; if (dut.u_fifo.count !== 5'd16) begin errors++; $display("FAIL ovf_count: got %0d expected 16", dut.u_fifo.count); end
    dout_ready = 1'b1;
    wait_words(2 * FLEN, 80);
    tick(); tick(); tick();
    for (int c = 0; c < 20; c++) tick();
    checks++; if (cap_d.size() != 2 * FLEN) begin errors++; $display("FAIL ovf_len: got %0d words expected %0d", cap_d.size(), 2 * FLEN); end
    n = (cap_d.size() < 2 * FLEN) ? cap_d.size() : 2 * FLEN;
    for (int j = 0; j < n; j++) begin
      checks++; if (cap_d[j] !== exp_word(32'h40 + 8 * (j / FLEN), j % FLEN)) begin errors++; $display("FAIL ovf_word[%0d]: got %h expected %h", j, cap_d[j], exp_word(32'h40 + 8 * (j / FLEN), j % FLEN)); end
      checks++; if (cap_eof[j] !== (j % FLEN == FLEN - 1)) begin errors++; $display("FAIL ovf_eof[%0d]: got %b expected %b", j, cap_eof[j], (j % FLEN == FLEN - 1)); end
    end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL ovf_frame_cnt: got %0d expected 2", frame_cnt); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", overflow); end
  endtask

  // Runs straight after test_overflow, so frame_cnt and overflow start nonzero.
  task automatic test_reset_midframe();
    int last_cyc;
    int n;
    clear_capture();
    dout_ready = 1'b1;
    write_words(17'h60, 8, last_cyc);
    for (int c = 0; c < 50 && cap_d.size() < 4; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++; if (dout_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %b expected 0", dout_valid); end
    checks++; if (dut.u_fifo.count !== 5'd0) begin errors++; $display("FAIL mid_fifo: got %0d expected 0", dut.u_fifo.count); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL mid_frame_cnt: got %0d expected 0", frame_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow: got %b expected 0", overflow); end
    checks++; if (cap_d.size() != 4) begin errors++; $display("FAIL mid_partial_len: got %0d words expected 4", cap_d.size()); end
    n = (cap_d.size() < 4) ? cap_d.size() : 4;
    for (int k = 0; k < n; k++) begin
      checks++; if (cap_d[k] !== exp_word(32'h60, k)) begin errors++; $display("FAIL mid_partial_word[%0d]: got %h expected %h", k, cap_d[k], exp_word(32'h60, k)); end
      checks++; if (cap_eof[k] !== 1'b0) begin errors++; $display("FAIL mid_partial_eof[%0d]: got %b expected 0", k, cap_eof[k]); end
    end
    clear_capture();
    write_words(17'h70, 8, last_cyc);
    wait_words(FLEN, 60);
    checks++; if (cap_d.size() != FLEN) begin errors++; $display("FAIL mid_new_len: got %0d words expected %0d", cap_d.size(), FLEN); end
    n = (cap_d.size() < FLEN) ? cap_d.size() : FLEN;
    for (int k = 0; k < n; k++) begin
      checks++; if (cap_d[k] !== exp_word(32'h70, k)) begin errors++; $display("FAIL mid_new_word[%0d]: got %h expected %h", k, cap_d[k], exp_word(32'h70, k)); end
      checks++; if (cap_sof[k] !== (k == 0)) begin errors++; $display("FAIL mid_new_sof[%0d]: got %b expected %b", k, cap_sof[k], (k == 0)); end
      checks++; if (cap_eof[k] !== (k == FLEN - 1)) begin errors++; $display("FAIL mid_new_eof[%0d]: got %b expected %b", k, cap_eof[k], (k == FLEN - 1)); end
    end
    tick(); tick(); tick();
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL mid_new_frame_cnt: got %0d expected 1", frame_cnt); end
  endtask

  task automatic test_counter_wrap();
    int last_cyc;
    do_reset();
    force dut.frame_cnt = 16'hFFFF;
    tick();
    release dut.frame_cnt;
    tick();
    checks++; if (frame_cnt !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload: got %h expected ffff", frame_cnt); end
    dout_ready = 1'b1;
    write_words(17'h80, 8, last_cyc);
    wait_words(FLEN, 60);
    tick(); tick(); tick();
    checks++; if (cap_d.size() != FLEN) begin errors++; $display("FAIL wrap_len: got %0d words expected %0d", cap_d.size(), FLEN); end
    checks++; if (frame_cnt !== 16'h0000) begin errors++; $display("FAIL wrap_frame_cnt: got %h expected 0000", frame_cnt); end
  endtask

  initial begin
    rst        = 1'b1;
    din        = '0;
    din_valid  = 1'b0;
    dout_ready = 1'b0;
    tick();
    test_reset();
    test_basic();
    test_backpressure();
    test_back_to_back();
    test_overflow();
    test_reset_midframe();
    test_counter_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
